// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the MEM-stage load/store unit and data memory.
// Word-wide req/ack bus. The master raises dmem_req and holds the request
// fields stable until the slave answers with dmem_ack. On a read, the slave
// supplies dmem_rdata in the same cycle as dmem_ack.
//   dmem_req   : request valid (master -> slave)
//   dmem_we    : 1 = write, 0 = read (master -> slave)
//   dmem_addr  : word-aligned byte address (master -> slave)
//   dmem_be    : per-byte lane enables (master -> slave)
//   dmem_wdata : lane-steered write data (master -> slave)
//   dmem_ack   : transaction completes this cycle (slave -> master)
//   dmem_rdata : read word, valid with dmem_ack (slave -> master)
interface mem_access_unit_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit.
// The unit turns an EX/MEM load or store into one req/ack transaction on the
// data-memory bus. It steers bytes and halfwords onto the correct lanes and
// sign- or zero-extends load data. While the bus transaction is in flight, it
// stalls the pipeline.
// Ports:
//   clk, reset      : rising-edge clock, asynchronous active-high reset
//   MEM_MemRead/Write, MEM_ALUResult, MEM_WriteData, MEM_Size, MEM_Unsigned
//                   : access request from EX/MEM (held frozen while stalled)
//   MEM_MemoryData  : registered, extended load data for MEM/WB
//   MEM_Stall       : combinational pipeline freeze
//   MEM_Misaligned  : combinational alignment fault for the instruction in IDLE
//   MEM_BusError    : one-cycle pulse in DONE after an ack timeout
//   dmem            : data-memory bus, master side (all outputs registered)
module mem_access_unit #(
  parameter int ACK_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                MEM_MemRead,
  input  logic                MEM_MemWrite,
  input  logic [31:0]         MEM_ALUResult,
  input  logic [31:0]         MEM_WriteData,
  input  logic [1:0]          MEM_Size,
  input  logic                MEM_Unsigned,
  output logic [31:0]         MEM_MemoryData,
  output logic                MEM_Stall,
  output logic                MEM_Misaligned,
  output logic                MEM_BusError,
  mem_access_unit_if.master   dmem
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               req_q, req_d, we_q, we_d, bus_err_q, bus_err_d, uns_q, uns_d;
  logic [31:0]        addr_q, addr_d, wdata_q, wdata_d, data_q, data_d;
  logic [3:0]         be_q, be_d;
  logic [1:0]         lo_q, lo_d, size_q, size_d;
  logic               access_s, misaligned_s;

  // Little-endian byte enables for a given size and address offset.
  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   lane_be = 4'b0001 << lo;
      2'b01:   lane_be = lo[1] ? 4'b1100 : 4'b0011;
      default: lane_be = 4'b1111;
    endcase
  endfunction

  // Replicate narrow store data across all lanes so that any enabled lane
  // carries the right bits.
  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      2'b00:   lane_wdata = {4{wd[7:0]}};
      2'b01:   lane_wdata = {2{wd[15:0]}};
      default: lane_wdata = wd;
    endcase
  endfunction

  // Select the addressed byte or halfword from the read word, then extend it.
  function automatic logic [31:0] load_extend(input logic [1:0] size, input logic [1:0] lo,
                                              input logic uns, input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[8*lo +: 8];
    h = lo[1] ? rd[31:16] : rd[15:0];
    case (size)
      2'b00:   load_extend = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      2'b01:   load_extend = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      default: load_extend = rd;
    endcase
  endfunction

  assign access_s     = MEM_MemRead | MEM_MemWrite;
  assign misaligned_s = access_s & (((MEM_Size == 2'b01) & MEM_ALUResult[0]) |
                                    (MEM_Size[1] & (MEM_ALUResult[1:0] != 2'b00)));

  // In REQ and DONE the EX/MEM inputs are frozen and were already checked, so
  // only the instruction being evaluated in IDLE reports misalignment.
  assign MEM_Misaligned = (state_q == IDLE) & misaligned_s;
  assign MEM_Stall      = ((state_q == IDLE) & access_s & ~misaligned_s) | (state_q == REQ);

  assign MEM_MemoryData  = data_q;
  assign MEM_BusError    = bus_err_q;
  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_be    = be_q;
  assign dmem.dmem_wdata = wdata_q;

  // Next-state, bus-register and load-result logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    data_d    = data_q;
    lo_d      = lo_q;
    size_d    = size_q;
    uns_d     = uns_q;
    bus_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (access_s & ~misaligned_s) begin
          req_d   = 1'b1;
          we_d    = MEM_MemWrite;
          addr_d  = {MEM_ALUResult[31:2], 2'b00};
          be_d    = lane_be(MEM_Size, MEM_ALUResult[1:0]);
          wdata_d = lane_wdata(MEM_Size, MEM_WriteData);
          lo_d    = MEM_ALUResult[1:0];
          size_d  = MEM_Size;
          uns_d   = MEM_Unsigned;
          cnt_d   = {CNT_W{1'b0}};
          state_d = REQ;
        end else if (misaligned_s) begin
          data_d = 32'h0000_0000;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (dmem.dmem_ack) begin
          data_d  = we_q ? 32'h0000_0000 : load_extend(size_q, lo_q, uns_q, dmem.dmem_rdata);
          req_d   = 1'b0;
          we_d    = 1'b0;
          be_d    = 4'b0000;
          state_d = DONE;
        end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
          data_d    = 32'h0000_0000;
          req_d     = 1'b0;
          we_d      = 1'b0;
          be_d      = 4'b0000;
          bus_err_d = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'h0000_0000;
      be_q      <= 4'b0000;
      wdata_q   <= 32'h0000_0000;
      data_q    <= 32'h0000_0000;
      lo_q      <= 2'b00;
      size_q    <= 2'b00;
      uns_q     <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      data_q    <= data_d;
      lo_q      <= lo_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      bus_err_q <= bus_err_d;
    end
  end

endmodule
